// File: rtl/jtlabrun_gfx_cpuif_pkg.sv
// Shared constants, bus decode categories and the CPU address decoder
// for the video-side CPU responder.
package jtlabrun_gfx_cpuif_pkg;

  localparam logic [2:0]  REG_CTRL  = 3'd4;
  localparam int          CTRL_NMI  = 0;
  localparam int          CTRL_IRQ  = 1;
  localparam int          CTRL_FLIP = 3;
  localparam logic [11:0] COL_BASE  = 12'h020;
  localparam logic [11:0] COL_END   = 12'h060;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_REG,
    SEL_COL,
    SEL_VRAM
  } sel_e;

  function automatic sel_e decode(input logic vram_sel, input logic [11:0] a);
    if (vram_sel)      return SEL_VRAM;
    if (a < COL_BASE)  return SEL_REG;
    if (a < COL_END)   return SEL_COL;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/jtlabrun_gfx_cpuif_if.sv
// Main-CPU bus as seen by the video block: strobes, address, data both ways
// and the two interrupt lines back to the 6809.
interface jtlabrun_gfx_cpuif_if;
  logic        cpu_cen;
  logic        gfx_cs;
  logic [13:0] gfx_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_dout;
  logic [7:0]  gfx_dout;
  logic        gfx_irqn;
  logic        gfx_nmin;

  modport master (
    output cpu_cen, gfx_cs, gfx_addr, cpu_rnw, cpu_dout,
    input  gfx_dout, gfx_irqn, gfx_nmin
  );

  modport slave (
    input  cpu_cen, gfx_cs, gfx_addr, cpu_rnw, cpu_dout,
    output gfx_dout, gfx_irqn, gfx_nmin
  );
endinterface

// File: rtl/jtframe_dual_ram.sv
// Two-port RAM: port 0 read/write, port 1 read-only, both with 1 clk read
// latency; a read colliding with a port-0 write returns the old contents.
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtlabrun_gfx_cpuif.sv
// Video-side CPU responder: config registers, column-scroll RAM, VRAM,
// registered CPU read-back, VBLANK IRQ and line-based NMI generation.
module jtlabrun_gfx_cpuif
  import jtlabrun_gfx_cpuif_pkg::*;
#(
  parameter int NMI_SH  = 5,
  parameter int NMI_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  jtlabrun_gfx_cpuif_if.slave bus,
  input  logic [8:0]          vdump,
  input  logic                hs,
  input  logic                lvbl,
  input  logic [12:0]         vram_addr,
  output logic [7:0]          vram_data,
  input  logic [5:0]          col_addr,
  output logic [7:0]          col_data,
  output logic [8:0]          hscroll,
  output logic [7:0]          vscroll,
  output logic                flip
);

  localparam int CW = $clog2(NMI_LEN + 1);

  logic [7:0]    regs [8];
  logic [11:0]   a;
  sel_e          sel;
  logic          we;
  logic [5:0]    col_cpu_addr;
  logic [7:0]    vram_q;
  logic [7:0]    col_q;
  sel_e          rd_sel_p0;
  logic [7:0]    rd_reg_p0;
  logic [7:0]    dout;
  logic          ctrl_wr;
  logic          irq_clr;
  logic          lvbl_l;
  logic          hs_l;
  logic          lvbl_fall;
  logic          lvbl_rise;
  logic          nmi_trig;
  logic          irqn;
  logic [CW-1:0] nmi_cnt;
  logic          unused_vdump;

  assign a            = bus.gfx_addr[11:0];
  assign sel          = bus.gfx_cs ? decode(bus.gfx_addr[13], a) : SEL_NONE;
  assign we           = bus.cpu_cen & bus.gfx_cs & ~bus.cpu_rnw;
  assign col_cpu_addr = a[5:0] - COL_BASE[5:0];
  assign unused_vdump = ^vdump;

  // Bit 12 of the bus address selects the VRAM half directly (0x2000->0x000, 0x3000->0x1000)
  jtframe_dual_ram #(.DW(8), .AW(13)) u_vram (
    .clk   (clk),
    .data0 (bus.cpu_dout),
    .addr0 (bus.gfx_addr[12:0]),
    .we0   (we && sel == SEL_VRAM),
    .q0    (vram_q),
    .addr1 (vram_addr),
    .q1    (vram_data)
  );

  jtframe_dual_ram #(.DW(8), .AW(6)) u_colscr (
    .clk   (clk),
    .data0 (bus.cpu_dout),
    .addr0 (col_cpu_addr),
    .we0   (we && sel == SEL_COL),
    .q0    (col_q),
    .addr1 (col_addr),
    .q1    (col_data)
  );

  // p0: register file update and read-address capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      rd_sel_p0 <= SEL_NONE;
    end else begin
      if (we && sel == SEL_REG) regs[a[2:0]] <= bus.cpu_dout;
      rd_sel_p0 <= sel;
    end
  end

  always_ff @(posedge clk) rd_reg_p0 <= regs[a[2:0]];

  always_comb begin
    dout = 8'hFF;
    case (rd_sel_p0)
      SEL_REG:  dout = rd_reg_p0;
      SEL_COL:  dout = col_q;
      SEL_VRAM: dout = vram_q;
      default:  dout = 8'hFF;
    endcase
  end

  assign bus.gfx_dout = dout;

  assign ctrl_wr   = we && sel == SEL_REG && a[2:0] == REG_CTRL;
  assign irq_clr   = ctrl_wr & ~bus.cpu_dout[CTRL_IRQ];
  assign lvbl_fall = lvbl_l & ~lvbl;
  assign lvbl_rise = ~lvbl_l & lvbl;
  assign nmi_trig  = hs & ~hs_l & regs[REG_CTRL][CTRL_NMI] & ~|vdump[NMI_SH-1:0];

  // Edge detectors track the inputs even in reset so no false edge follows it
  always_ff @(posedge clk) begin
    lvbl_l <= lvbl;
    hs_l   <= hs;
    if (rst) begin
      irqn    <= 1'b1;
      nmi_cnt <= '0;
    end else begin
      if (irq_clr || lvbl_rise)
        irqn <= 1'b1;
      else if (lvbl_fall && regs[REG_CTRL][CTRL_IRQ])
        irqn <= 1'b0;
      if (nmi_trig)
        nmi_cnt <= CW'(NMI_LEN);
      else if (nmi_cnt != '0)
        nmi_cnt <= nmi_cnt - CW'(1);
    end
  end

  assign bus.gfx_irqn = irqn;
  assign bus.gfx_nmin = (nmi_cnt == '0);

  assign hscroll = {regs[1][0], regs[0]};
  assign vscroll = regs[2];
  assign flip    = regs[REG_CTRL][CTRL_FLIP];

endmodule

// File: tb/tb_jtlabrun_gfx_cpuif.sv
// Bench for jtlabrun_gfx_cpuif: vector table, interrupt sequences and a
// randomized CPU/video traffic run against an address-map model.
module tb_jtlabrun_gfx_cpuif;
  import jtlabrun_gfx_cpuif_pkg::*;

  localparam int NMI_SH  = 5;
  localparam int NMI_LEN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  vdump = '0;
  logic        hs = 1'b0;
  logic        lvbl = 1'b1;
  logic [12:0] vram_addr = '0;
  logic [7:0]  vram_data;
  logic [5:0]  col_addr = '0;
  logic [7:0]  col_data;
  logic [8:0]  hscroll;
  logic [7:0]  vscroll;
  logic        flip;

  always #5 clk = ~clk;

  jtlabrun_gfx_cpuif_if bus();

  jtlabrun_gfx_cpuif #(.NMI_SH(NMI_SH), .NMI_LEN(NMI_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .vdump     (vdump),
    .hs        (hs),
    .lvbl      (lvbl),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .col_addr  (col_addr),
    .col_data  (col_data),
    .hscroll   (hscroll),
    .vscroll   (vscroll),
    .flip      (flip)
  );

  int checks = 0;
  int errors = 0;

  // Address-map model of the CPU-visible storage
  logic [7:0] m_regs [8];
  logic [7:0] m_col  [64];
  logic [7:0] m_vram [8192];

  function automatic logic [7:0] m_read(input logic [13:0] addr);
    int off;
    off = int'(addr[11:0]);
    if (addr[13]) return m_vram[addr[12:0]];
    if (off < 32) return m_regs[off % 8];
    if (off < 96) return m_col[off - 32];
    return 8'hFF;
  endfunction

  task automatic m_write(input logic [13:0] addr, input logic [7:0] d);
    int off;
    off = int'(addr[11:0]);
    if (addr[13])      m_vram[addr[12:0]] = d;
    else if (off < 32) m_regs[off % 8] = d;
    else if (off < 96) m_col[off - 32] = d;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [13:0] addr, input logic [7:0] d);
    bus.gfx_cs   = 1'b1;
    bus.cpu_rnw  = 1'b0;
    bus.gfx_addr = addr;
    bus.cpu_dout = d;
    bus.cpu_cen  = 1'b1;
    tick();
    bus.cpu_cen  = 1'b0;
    bus.gfx_cs   = 1'b0;
    bus.cpu_rnw  = 1'b1;
    m_write(addr, d);
  endtask

  task automatic cpu_read(input logic [13:0] addr, output logic [7:0] d);
    bus.gfx_cs   = 1'b1;
    bus.cpu_rnw  = 1'b1;
    bus.gfx_addr = addr;
    tick();
    d = bus.gfx_dout;
    bus.gfx_cs   = 1'b0;
  endtask

  // NMI low-time monitor: each completed low pulse length lands in runs
  int run_len = 0;
  int runs[$];
  always @(negedge clk) begin
    if (bus.gfx_nmin === 1'b0) run_len++;
    else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0]  got;
    logic [13:0] addr;
    logic [7:0]  d;
    logic [7:0]  exp_v;
    logic [7:0]  exp_c;
    int          cat;
    int          exp_pulses;

    vecs.push_back('{1'b1, 14'h3000, 8'hA5, 8'hA5});
    vecs.push_back('{1'b1, 14'h0000, 8'h12, 8'h12});
    vecs.push_back('{1'b1, 14'h0009, 8'h01, 8'h01});
    vecs.push_back('{1'b1, 14'h0012, 8'h34, 8'h34});
    vecs.push_back('{1'b0, 14'h0001, 8'h00, 8'h01});
    vecs.push_back('{1'b0, 14'h0019, 8'h00, 8'h01});
    vecs.push_back('{1'b0, 14'h0060, 8'h00, 8'hFF});
    vecs.push_back('{1'b1, 14'h0060, 8'h5A, 8'hFF});
    vecs.push_back('{1'b0, 14'h0000, 8'h00, 8'h12});
    vecs.push_back('{1'b1, 14'h0020, 8'h77, 8'h77});
    vecs.push_back('{1'b1, 14'h005F, 8'h3C, 8'h3C});
    vecs.push_back('{1'b0, 14'h0020, 8'h00, 8'h77});
    vecs.push_back('{1'b1, 14'h2000, 8'h5E, 8'h5E});
    vecs.push_back('{1'b0, 14'h3000, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 14'h0FFF, 8'h00, 8'hFF});

    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

    // Reset with a register read held on the bus
    bus.cpu_cen  = 1'b0;
    bus.gfx_cs   = 1'b1;
    bus.cpu_rnw  = 1'b1;
    bus.gfx_addr = 14'h0004;
    bus.cpu_dout = 8'h00;
    repeat (3) tick();
    check("rst_dout", {8'h0, bus.gfx_dout}, 16'h00FF);
    check("rst_irqn", {15'h0, bus.gfx_irqn}, 16'h1);
    check("rst_nmin", {15'h0, bus.gfx_nmin}, 16'h1);
    check("rst_hscroll", {7'h0, hscroll}, 16'h0);
    check("rst_vscroll", {8'h0, vscroll}, 16'h0);
    check("rst_flip", {15'h0, flip}, 16'h0);
    rst = 1'b0;
    bus.gfx_cs = 1'b0;
    cpu_read(14'h0004, got);
    check("rd_reg4_after_rst", {8'h0, got}, 16'h0000);

    // Vector table: writes then read-backs
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].data);
      cpu_read(vecs[i].addr, got);
      check($sformatf("vec%0d_%0h", i, vecs[i].addr), {8'h0, got}, {8'h0, vecs[i].exp});
    end
    check("hscroll", {7'h0, hscroll}, 16'h0112);
    check("vscroll", {8'h0, vscroll}, 16'h0034);

    // Video read ports
    vram_addr = 13'h1000; col_addr = 6'd0;
    tick();
    check("vid_vram_1000", {8'h0, vram_data}, 16'h00A5);
    check("vid_col_0", {8'h0, col_data}, 16'h0077);
    vram_addr = 13'h0000; col_addr = 6'h3F;
    tick();
    check("vid_vram_0000", {8'h0, vram_data}, 16'h005E);
    check("vid_col_3f", {8'h0, col_data}, 16'h003C);

    // Bus cycle stretched over several clks with a single cpu_cen pulse
    bus.gfx_cs = 1'b1; bus.cpu_rnw = 1'b0; bus.gfx_addr = 14'h0003;
    bus.cpu_dout = 8'h4B; bus.cpu_cen = 1'b1;
    tick();
    bus.cpu_cen = 1'b0; bus.cpu_dout = 8'hC3;
    repeat (3) tick();
    bus.gfx_cs = 1'b0; bus.cpu_rnw = 1'b1;
    m_write(14'h0003, 8'h4B);
    cpu_read(14'h0003, got);
    check("one_write_per_cen", {8'h0, got}, 16'h004B);

    // Video read colliding with a CPU write returns the old byte
    cpu_write(14'h2005, 8'h11);
    vram_addr = 13'h0005;
    cpu_write(14'h2005, 8'h22);
    check("collide_old", {8'h0, vram_data}, 16'h0011);
    tick();
    check("collide_new", {8'h0, vram_data}, 16'h0022);

    // IRQ: enable, VBLANK start, then clear by writing irq_en=0
    cpu_write(14'h0004, 8'h02);
    check("irq_idle", {15'h0, bus.gfx_irqn}, 16'h1);
    lvbl = 1'b0;
    tick();
    check("irq_on_fall", {15'h0, bus.gfx_irqn}, 16'h0);
    cpu_write(14'h0004, 8'h00);
    check("irq_clr", {15'h0, bus.gfx_irqn}, 16'h1);
    lvbl = 1'b1; tick();
    lvbl = 1'b0; tick(); tick();
    check("irq_disabled", {15'h0, bus.gfx_irqn}, 16'h1);

    // IRQ released by lvbl rising
    lvbl = 1'b1; tick();
    cpu_write(14'h0004, 8'h02);
    lvbl = 1'b0; tick(); tick();
    check("irq_held", {15'h0, bus.gfx_irqn}, 16'h0);
    lvbl = 1'b1; tick();
    check("irq_lvbl_rise", {15'h0, bus.gfx_irqn}, 16'h1);

    // lvbl fall and irq_en clear on the same clk: clear wins
    lvbl = 1'b0;
    cpu_write(14'h0004, 8'h00);
    check("irq_clear_wins", {15'h0, bus.gfx_irqn}, 16'h1);
    tick();
    check("irq_clear_wins2", {15'h0, bus.gfx_irqn}, 16'h1);
    lvbl = 1'b1; tick();

    // NMI sweep over 64 lines
    cpu_write(14'h0004, 8'h01);
    runs.delete();
    exp_pulses = 0;
    for (int v = 0; v < 64; v++) begin
      if (v % (1 << NMI_SH) == 0) exp_pulses++;
      vdump = 9'(v); hs = 1'b1; tick();
      hs = 1'b0; repeat (23) tick();
    end
    repeat (4) tick();
    check("nmi_count", 16'(runs.size()), 16'(exp_pulses));
    foreach (runs[i]) check($sformatf("nmi_len%0d", i), 16'(runs[i]), 16'(NMI_LEN));

    // Retrigger during an active pulse restarts the count
    runs.delete();
    vdump = 9'd0; hs = 1'b1; tick();
    hs = 1'b0; repeat (4) tick();
    hs = 1'b1; tick();
    hs = 1'b0; repeat (30) tick();
    check("nmi_restart_n", 16'(runs.size()), 16'd1);
    if (runs.size() > 0) check("nmi_restart_len", 16'(runs[0]), 16'(5 + NMI_LEN));

    // Line not on the NMI period
    runs.delete();
    vdump = 9'd1; hs = 1'b1; tick();
    hs = 1'b0; repeat (20) tick();
    check("nmi_off_line", 16'(runs.size()), 16'd0);

    // Clearing nmi_en mid-pulse keeps the full length; afterwards no trigger
    vdump = 9'd0; hs = 1'b1; tick();
    hs = 1'b0; tick();
    cpu_write(14'h0004, 8'h00);
    repeat (25) tick();
    check("nmi_keep_n", 16'(runs.size()), 16'd1);
    if (runs.size() > 0) check("nmi_keep_len", 16'(runs[0]), 16'(NMI_LEN));
    runs.delete();
    hs = 1'b1; tick();
    hs = 1'b0; repeat (20) tick();
    check("nmi_disabled", 16'(runs.size()), 16'd0);

    // Reset during active IRQ and NMI
    cpu_write(14'h0004, 8'h03);
    lvbl = 1'b0; vdump = 9'd0; hs = 1'b1; tick();
    hs = 1'b0;
    check("pre_rst_irqn", {15'h0, bus.gfx_irqn}, 16'h0);
    check("pre_rst_nmin", {15'h0, bus.gfx_nmin}, 16'h0);
    rst = 1'b1; tick();
    check("rst_mid_irqn", {15'h0, bus.gfx_irqn}, 16'h1);
    check("rst_mid_nmin", {15'h0, bus.gfx_nmin}, 16'h1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    lvbl = 1'b1; tick();
    check("rst_mid_hscroll", {7'h0, hscroll}, 16'h0);
    cpu_read(14'h3000, got);
    check("vram_kept", {8'h0, got}, 16'h00A5);
    repeat (20) tick();
    runs.delete();

    // Randomized traffic: seed a VRAM window and all of colscr first
    for (int i = 0; i < 32; i++) begin
      cpu_write(14'h2000 | 14'(i), 8'($urandom));
      cpu_write(14'h3000 | 14'(i), 8'($urandom));
    end
    for (int i = 0; i < 64; i++) cpu_write(14'h0020 + 14'(i), 8'($urandom));

    for (int n = 0; n < 400; n++) begin
      cat = int'($urandom_range(0, 3));
      case (cat)
        0:       addr = {1'b0, 1'($urandom), 12'($urandom_range(0, 31))};
        1:       addr = {1'b0, 1'($urandom), 12'(32 + $urandom_range(0, 63))};
        2:       addr = {1'b0, 1'($urandom), 12'($urandom_range(96, 4095))};
        default: addr = {1'b1, 1'($urandom), 7'b0, 5'($urandom_range(0, 31))};
      endcase
      d = 8'($urandom);
      vram_addr = {1'($urandom), 7'b0, 5'($urandom)};
      col_addr  = 6'($urandom);
      exp_v = m_vram[vram_addr];
      exp_c = m_col[col_addr];
      if ($urandom_range(0, 1) == 1) cpu_write(addr, d);
      else begin
        cpu_read(addr, got);
        check($sformatf("rnd_rd_%0h", addr), {8'h0, got}, {8'h0, m_read(addr)});
      end
      check("rnd_vram", {8'h0, vram_data}, {8'h0, exp_v});
      check("rnd_col", {8'h0, col_data}, {8'h0, exp_c});
      check("rnd_hscroll", {7'h0, hscroll}, {7'h0, m_regs[1][0], m_regs[0]});
      check("rnd_vscroll", {8'h0, vscroll}, {8'h0, m_regs[2]});
      check("rnd_flip", {15'h0, flip}, {15'h0, m_regs[4][3]});
    end
    check("rnd_irqn", {15'h0, bus.gfx_irqn}, 16'h1);
    check("rnd_nmin", {15'h0, bus.gfx_nmin}, 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
